// File: rtl/axis_ring_writer.sv
// AXI-Stream to AXI4 ring-buffer writer: one INCR burst per fixed-length packet,
// wrap-around ring pointer, outstanding-burst limit tracked through B responses.
module axis_ring_writer #(
    parameter int DATA_WBITS      = 512,
    parameter int ADDR_WBITS      = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [8:0]              CYCLES_PER_PACKET,
    input  logic [ADDR_WBITS-1:0]   RING_BASE,
    input  logic [31:0]             RING_SIZE,
    input  logic [DATA_WBITS-1:0]   AXIS_IN_TDATA,
    input  logic                    AXIS_IN_TVALID,
    input  logic                    AXIS_IN_TLAST,
    output logic                    AXIS_IN_TREADY,
    output logic [ADDR_WBITS-1:0]   M_AXI_AWADDR,
    output logic [7:0]              M_AXI_AWLEN,
    output logic [2:0]              M_AXI_AWSIZE,
    output logic [1:0]              M_AXI_AWBURST,
    output logic                    M_AXI_AWID,
    output logic                    M_AXI_AWLOCK,
    output logic [3:0]              M_AXI_AWCACHE,
    output logic [3:0]              M_AXI_AWQOS,
    output logic [2:0]              M_AXI_AWPROT,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WBITS-1:0]   M_AXI_WDATA,
    output logic [DATA_WBITS/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WLAST,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY,
    output logic [31:0]             PACKETS_WRITTEN,
    output logic [7:0]              OUTSTANDING,
    output logic                    BRESP_ERR,
    output logic                    FRAMING_ERR
);
    localparam int         BYTES   = DATA_WBITS / 8;
    localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             ptr_q, ptr_d;
    logic [8:0]              beat_q, beat_d;
    logic [7:0]              out_q, out_d;
    logic [31:0]             pkts_q, pkts_d;
    logic                    berr_q, berr_d;
    logic                    ferr_q, ferr_d;
    logic                    awvalid_q, awvalid_d;
    logic [ADDR_WBITS-1:0]   awaddr_q, awaddr_d;
    logic [7:0]              awlen_q, awlen_d;

    logic [8:0]              cpp_m1;
    logic [31:0]             pkt_bytes;
    logic [32:0]             ptr_sum;
    logic                    aw_hs, w_hs, wlast;

    assign cpp_m1    = CYCLES_PER_PACKET - 9'd1;
    assign pkt_bytes = 32'(CYCLES_PER_PACKET) * 32'(BYTES);
    // 33-bit sum so a ring near 4GB cannot alias the wrap compare
    assign ptr_sum   = {1'b0, ptr_q} + {1'b0, pkt_bytes};

    assign aw_hs = awvalid_q & M_AXI_AWREADY;
    assign wlast = (state_q == S_DATA) && (beat_q == cpp_m1);
    assign w_hs  = (state_q == S_DATA) & AXIS_IN_TVALID & M_AXI_WREADY;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        out_d     = out_q;
        pkts_d    = pkts_q;
        berr_d    = berr_q;
        ferr_d    = ferr_q;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;

        case (state_q)
            S_IDLE: if (AXIS_IN_TVALID && (out_q < MAX_OUT)) begin
                state_d   = S_ADDR;
                awvalid_d = 1'b1;
                awaddr_d  = RING_BASE + ADDR_WBITS'(ptr_q);
                awlen_d   = cpp_m1[7:0];
            end
            S_ADDR: if (aw_hs) begin
                state_d   = S_DATA;
                awvalid_d = 1'b0;
                beat_d    = 9'd0;
            end
            S_DATA: if (w_hs) begin
                if (wlast) begin
                    state_d = S_IDLE;
                    beat_d  = 9'd0;
                    ptr_d   = (ptr_sum >= {1'b0, RING_SIZE}) ? 32'd0 : ptr_sum[31:0];
                end else begin
                    beat_d  = beat_q + 9'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // TLAST is only audited; burst length always comes from the beat counter
        if (w_hs && (AXIS_IN_TLAST != wlast))
            ferr_d = 1'b1;

        case ({aw_hs, M_AXI_BVALID})
            2'b10:   out_d = out_q + 8'd1;
            2'b01:   out_d = (out_q != 8'd0) ? out_q - 8'd1 : 8'd0;
            default: out_d = out_q;
        endcase

        if (M_AXI_BVALID) begin
            pkts_d = pkts_q + 32'd1;
            if (M_AXI_BRESP != 2'b00)
                berr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            beat_q    <= '0;
            out_q     <= '0;
            pkts_q    <= '0;
            berr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            beat_q    <= beat_d;
            out_q     <= out_d;
            pkts_q    <= pkts_d;
            berr_q    <= berr_d;
            ferr_q    <= ferr_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
        end
    end

    assign M_AXI_AWADDR    = awaddr_q;
    assign M_AXI_AWLEN     = awlen_q;
    assign M_AXI_AWVALID   = awvalid_q;
    assign M_AXI_AWSIZE    = 3'($clog2(BYTES));
    assign M_AXI_AWBURST   = 2'b01;
    assign M_AXI_AWID      = 1'b0;
    assign M_AXI_AWLOCK    = 1'b0;
    assign M_AXI_AWCACHE   = 4'd0;
    assign M_AXI_AWQOS     = 4'd0;
    assign M_AXI_AWPROT    = 3'd1;

    assign M_AXI_WDATA     = AXIS_IN_TDATA;
    assign M_AXI_WSTRB     = '1;
    assign M_AXI_WLAST     = wlast;
    assign M_AXI_WVALID    = (state_q == S_DATA) & AXIS_IN_TVALID;
    assign AXIS_IN_TREADY  = (state_q == S_DATA) & M_AXI_WREADY;
    assign M_AXI_BREADY    = 1'b1;

    assign PACKETS_WRITTEN = pkts_q;
    assign OUTSTANDING     = out_q;
    assign BRESP_ERR       = berr_q;
    assign FRAMING_ERR     = ferr_q;
endmodule

// File: tb/tb_axis_ring_writer.sv
// Randomized bench for axis_ring_writer: an AXI slave/stream source pair feeds the DUT
// and every burst is compared with a packet-level model of ring addressing and data.
module tb_axis_ring_writer;
    localparam int DW = 512;
    localparam int AW = 64;
    localparam int MO = 2;
    localparam int BB = DW / 8;

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [8:0]      cpp = 9'd4;
    logic [AW-1:0]   base = '0;
    logic [31:0]     rsize = 32'd1024;
    logic [DW-1:0]   tdata = '0;
    logic            tvalid = 1'b0, tlast = 1'b0, tready;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize, awprot;
    logic [1:0]      awburst;
    logic            awid, awlock, awvalid;
    logic [3:0]      awcache, awqos;
    logic            awready = 1'b1;
    logic [DW-1:0]   wdata;
    logic [BB-1:0]   wstrb;
    logic            wlast, wvalid;
    logic            wready = 1'b1;
    logic [1:0]      bresp = 2'b00;
    logic            bvalid = 1'b0, bready;
    logic [31:0]     pw;
    logic [7:0]      outst;
    logic            berr, ferr;

    axis_ring_writer #(.DATA_WBITS(DW), .ADDR_WBITS(AW), .MAX_OUTSTANDING(MO)) dut (
        .clk(clk), .resetn(resetn), .CYCLES_PER_PACKET(cpp), .RING_BASE(base), .RING_SIZE(rsize),
        .AXIS_IN_TDATA(tdata), .AXIS_IN_TVALID(tvalid), .AXIS_IN_TLAST(tlast), .AXIS_IN_TREADY(tready),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst),
        .M_AXI_AWID(awid), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache), .M_AXI_AWQOS(awqos),
        .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
        .M_AXI_WREADY(wready), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .PACKETS_WRITTEN(pw), .OUTSTANDING(outst), .BRESP_ERR(berr), .FRAMING_ERR(ferr)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    logic [DW-1:0] src_d[$];
    logic          src_l[$];
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];
    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] w_obs[$];
    logic          wl_obs[$];
    logic [AW-1:0] awa_obs[$];
    logic [7:0]    awl_obs[$];
    int            bursts_done = 0, b_sent = 0, pkt_idx = 0;
    bit            b_en = 1'b1, wr_rand = 1'b0, tv_rand = 1'b0, aw_hold = 1'b0, w_hs_f = 1'b0;
    logic [1:0]    bresp_next = 2'b00;

    // Monitor: at negedge all signals are stable for the coming posedge.
    initial forever begin
        @(negedge clk);
        w_hs_f = resetn && tvalid && tready;
        if (resetn && awvalid && awready) begin
            awa_obs.push_back(awaddr);
            awl_obs.push_back(awlen);
        end
        if (resetn && wvalid && wready) begin
            w_obs.push_back(wdata);
            wl_obs.push_back(wlast);
            if (wlast) bursts_done++;
        end
    end

    // Stream source and AXI slave, driven just after each posedge.
    initial forever begin
        @(posedge clk);
        #1;
        if (!resetn) begin
            tvalid = 1'b0;
            bvalid = 1'b0;
        end else begin
            if (w_hs_f && src_d.size() > 0) begin
                void'(src_d.pop_front());
                void'(src_l.pop_front());
            end
            if (src_d.size() == 0) tvalid = 1'b0;
            else if (!tvalid || w_hs_f) tvalid = tv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            tdata  = (src_d.size() > 0) ? src_d[0] : '0;
            tlast  = (src_l.size() > 0) ? src_l[0] : 1'b0;
            wready = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            awready = !aw_hold;
            if (bvalid) bvalid = 1'b0;
            else if (b_en && b_sent < bursts_done) begin
                bvalid = 1'b1;
                bresp  = bresp_next;
                b_sent++;
            end
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // Model: packet k lands at base + (k*PKT mod RING_SIZE); WLAST on beat CPP-1 only.
    task automatic send_pkt(input int tlast_at);
        longint off;
        logic [DW-1:0] d;
        off = (longint'(pkt_idx) * longint'(cpp) * longint'(BB)) % longint'(rsize);
        exp_a.push_back(base + 64'(off));
        pkt_idx++;
        for (int b = 0; b < int'(cpp); b++) begin
            d = rnd_data();
            src_d.push_back(d);
            src_l.push_back((tlast_at < 0) ? (b == int'(cpp) - 1) : (b == tlast_at));
            exp_d.push_back(d);
            exp_l.push_back(b == int'(cpp) - 1);
        end
    endtask

    task automatic do_reset(input logic [8:0] c, input logic [AW-1:0] b, input logic [31:0] s);
        resetn = 1'b0;
        tick();
        src_d.delete(); src_l.delete(); exp_d.delete(); exp_l.delete(); exp_a.delete();
        w_obs.delete(); wl_obs.delete(); awa_obs.delete(); awl_obs.delete();
        bursts_done = 0; b_sent = 0; pkt_idx = 0;
        cpp = c; base = b; rsize = s;
        wr_rand = 1'b0; tv_rand = 1'b0; aw_hold = 1'b0; b_en = 1'b1; bresp_next = 2'b00;
        tick();
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic wait_pw(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (pw == 32'(n) && outst == 8'd0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || tready !== 1'b0) begin
            errors++; $display("FAIL reset_valids: aw=%b w=%b tr=%b required 0 0 0", awvalid, wvalid, tready); end
        checks++; if (bready !== 1'b1) begin errors++; $display("FAIL reset_bready: got %b required 1", bready); end
        checks++; if (pw !== 32'd0 || outst !== 8'd0) begin
            errors++; $display("FAIL reset_counters: pw=%0d out=%0d required 0 0", pw, outst); end
        checks++; if (berr !== 1'b0 || ferr !== 1'b0) begin
            errors++; $display("FAIL reset_flags: berr=%b ferr=%b required 0 0", berr, ferr); end
        checks++; if (awaddr !== '0 || awlen !== 8'd0) begin
            errors++; $display("FAIL reset_aw: addr=%h len=%0d required 0 0", awaddr, awlen); end
        checks++; if (awsize !== 3'd6 || awburst !== 2'd1 || awprot !== 3'd1 || wstrb !== {BB{1'b1}}) begin
            errors++; $display("FAIL reset_consts: size=%0d burst=%0d prot=%0d required 6 1 1", awsize, awburst, awprot); end
    endtask

    task automatic test_ring_wrap();
        bit ok;
        logic [AW-1:0] want [4];
        want[0] = 64'h1000; want[1] = 64'h1100; want[2] = 64'h1200; want[3] = 64'h1000;
        do_reset(9'd4, 64'h1000, 32'd768);
        for (int k = 0; k < 4; k++) send_pkt(-1);
        wait_pw(4, 500, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wrap_done: pw=%0d required 4", pw); end
        checks++; if (awa_obs.size() != 4) begin
            errors++; $display("FAIL wrap_awcount: got %0d required 4", awa_obs.size()); end
        for (int k = 0; k < 4 && k < awa_obs.size(); k++) begin
            checks++; if (awa_obs[k] !== want[k] || awl_obs[k] !== 8'd3) begin
                errors++; $display("FAIL wrap_aw%0d: addr=%h len=%0d required %h 3", k, awa_obs[k], awl_obs[k], want[k]); end
        end
        checks++; if (w_obs.size() != exp_d.size() || w_obs != exp_d || wl_obs != exp_l) begin
            errors++; $display("FAIL wrap_data: got %0d beats required %0d matching beats", w_obs.size(), exp_d.size()); end
    endtask

    task automatic test_aw_stall();
        bit ok, seen;
        logic [AW-1:0] want;
        do_reset(9'd4, 64'h2000, 32'd1024);
        aw_hold = 1'b1;
        send_pkt(-1);
        want = exp_a[0];
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = awvalid; end
        checks++; if (!seen) begin errors++; $display("FAIL stall_awvalid: got 0 required 1"); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (awvalid !== 1'b1 || awaddr !== want || tready !== 1'b0 || wvalid !== 1'b0) begin
                errors++; $display("FAIL stall_cycle%0d: aw=%b addr=%h tr=%b w=%b required 1 %h 0 0",
                    i, awvalid, awaddr, tready, wvalid, want); end
            tick();
        end
        aw_hold = 1'b0;
        wait_pw(1, 200, ok);
        checks++; if (!ok || w_obs != exp_d || wl_obs != exp_l) begin
            errors++; $display("FAIL stall_burst: pw=%0d beats=%0d required 1 4", pw, w_obs.size()); end
    endtask

    task automatic test_outstanding();
        bit ok;
        do_reset(9'd4, 64'h4000, 32'd768);
        b_en = 1'b0;
        for (int k = 0; k < 5; k++) send_pkt(-1);
        repeat (150) tick();
        checks++; if (awa_obs.size() != 2 || outst !== 8'd2) begin
            errors++; $display("FAIL limit_hold: aw=%0d out=%0d required 2 2", awa_obs.size(), outst); end
        checks++; if (tready !== 1'b0 || pw !== 32'd0 || w_obs.size() != 8) begin
            errors++; $display("FAIL limit_idle: tr=%b pw=%0d beats=%0d required 0 0 8", tready, pw, w_obs.size()); end
        b_en = 1'b1;
        wait_pw(5, 2000, ok);
        checks++; if (!ok || awa_obs != exp_a) begin
            errors++; $display("FAIL limit_resume: pw=%0d aw=%0d required 5 5 matching", pw, awa_obs.size()); end
        checks++; if (w_obs != exp_d || wl_obs != exp_l) begin
            errors++; $display("FAIL limit_data: beats=%0d required %0d matching", w_obs.size(), exp_d.size()); end
    endtask

    task automatic test_random(input logic [8:0] c, input int n, input logic [31:0] s);
        bit ok;
        do_reset(c, 64'h10000, s);
        wr_rand = 1'b1;
        tv_rand = 1'b1;
        for (int k = 0; k < n; k++) send_pkt(-1);
        wait_pw(n, 6000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rand%0d_done: pw=%0d required %0d", c, pw, n); end
        checks++; if (awa_obs != exp_a || awl_obs.size() != n) begin
            errors++; $display("FAIL rand%0d_aw: got %0d bursts required %0d matching", c, awa_obs.size(), n); end
        for (int i = 0; i < exp_d.size(); i++) begin
            logic [DW-1:0] got;
            logic gl;
            got = (i < w_obs.size()) ? w_obs[i] : 'x;
            gl  = (i < wl_obs.size()) ? wl_obs[i] : 1'bx;
            checks++; if (got !== exp_d[i] || gl !== exp_l[i]) begin
                errors++; $display("FAIL rand%0d_beat%0d: data=%h last=%b required %h %b",
                    c, i, got[63:0], gl, exp_d[i][63:0], exp_l[i]); end
        end
    endtask

    task automatic test_errors();
        bit ok;
        do_reset(9'd4, 64'h0, 32'd1024);
        send_pkt(-1);
        wait_pw(1, 200, ok);
        checks++; if (!ok || ferr !== 1'b0 || berr !== 1'b0) begin
            errors++; $display("FAIL err_clean: pw=%0d ferr=%b berr=%b required 1 0 0", pw, ferr, berr); end
        bresp_next = 2'b10;
        send_pkt(1);
        wait_pw(2, 200, ok);
        checks++; if (!ok || ferr !== 1'b1 || berr !== 1'b1) begin
            errors++; $display("FAIL err_flags: pw=%0d ferr=%b berr=%b required 2 1 1", pw, ferr, berr); end
        checks++; if (w_obs.size() != 8 || w_obs != exp_d || wl_obs != exp_l) begin
            errors++; $display("FAIL err_burst: beats=%0d required 8 with WLAST on beat 3 only", w_obs.size()); end
    endtask

    task automatic test_mid_reset();
        bit ok, hit;
        do_reset(9'd4, 64'h3000, 32'd1024);
        b_en = 1'b0;
        send_pkt(-1);
        send_pkt(-1);
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin tick(); hit = (w_obs.size() >= 6); end
        checks++; if (!hit || outst !== 8'd2) begin
            errors++; $display("FAIL mrst_setup: beats=%0d out=%0d required 6 2", w_obs.size(), outst); end
        resetn = 1'b0;
        tick();
        checks++; if (awvalid !== 1'b0 || wvalid !== 1'b0 || tready !== 1'b0 || outst !== 8'd0) begin
            errors++; $display("FAIL mrst_abandon: aw=%b w=%b tr=%b out=%0d required 0 0 0 0",
                awvalid, wvalid, tready, outst); end
        do_reset(9'd4, 64'h3000, 32'd1024);
        send_pkt(-1);
        wait_pw(1, 200, ok);
        checks++; if (!ok || awa_obs.size() != 1 || awa_obs[0] !== 64'h3000) begin
            errors++; $display("FAIL mrst_restart: pw=%0d aw=%0d addr=%h required 1 1 3000",
                pw, awa_obs.size(), (awa_obs.size() > 0) ? awa_obs[0] : '0); end
        checks++; if (w_obs != exp_d || wl_obs != exp_l) begin
            errors++; $display("FAIL mrst_data: beats=%0d required 4 matching", w_obs.size()); end
    endtask

    initial begin
        test_reset();
        test_ring_wrap();
        test_aw_stall();
        test_outstanding();
        test_random(9'd1, 6, 32'd256);
        test_random(9'd256, 2, 32'd32768);
        test_errors();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
